buffer_credit_reg_based: RTL and testbench



---
 rtl/buffer_credit_reg_based.sv | 96 +++++++++
 tb/tb_buffer_credit_reg_based.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_credit_reg_based.sv
// Credit-gated register buffer at the return end of a fixed-latency, non-stallable path.
// Launches are metered by credits so that returning data always finds a free slot.
module buffer_credit_reg_based #(
  parameter  int SIZE    = 4,
  parameter  int DATA_WD = 8,
  localparam int CNT_WD  = $clog2(SIZE + 1),
  localparam int PTR_WD  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_val_i,
  output logic               req_rdy_o,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  input  logic               rdy_i,
  output logic [CNT_WD-1:0]  cnt_crd_o,
  output logic               err_o
);

  logic [DATA_WD-1:0] r_mem [SIZE];
  logic [PTR_WD-1:0]  r_wr_ptr;
  logic [PTR_WD-1:0]  r_rd_ptr;
  logic [CNT_WD-1:0]  r_cnt_usd;
  logic [CNT_WD-1:0]  r_cnt_crd;
  logic               r_err;

  logic w_launch;
  logic w_pop;
  logic w_full;
  logic w_wr;

  // Pointers wrap explicitly so SIZE need not be a power of two.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] ptr);
    return (ptr == PTR_WD'(SIZE - 1)) ? '0 : ptr + PTR_WD'(1);
  endfunction

  assign req_rdy_o = (r_cnt_crd != '0);
  assign val_o     = (r_cnt_usd != '0);
  assign dat_o     = r_mem[r_rd_ptr];
  assign cnt_crd_o = r_cnt_crd;
  assign err_o     = r_err;

  assign w_launch = req_val_i & req_rdy_o;
  assign w_pop    = val_o & rdy_i;
  assign w_full   = (r_cnt_usd == CNT_WD'(SIZE));
  // A simultaneous pop frees the head slot, so a write while full is still safe.
  assign w_wr     = val_i & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_crd <= CNT_WD'(SIZE);
    end else if (w_launch && !w_pop) begin
      r_cnt_crd <= r_cnt_crd - CNT_WD'(1);
    end else if (w_pop && !w_launch) begin
      r_cnt_crd <= r_cnt_crd + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt_usd <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr && !w_pop) begin
        r_cnt_usd <= r_cnt_usd + CNT_WD'(1);
      end else if (w_pop && !w_wr) begin
        r_cnt_usd <= r_cnt_usd - CNT_WD'(1);
      end
      if (val_i && w_full && !w_pop) r_err <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; val_o qualifies dat_o.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= dat_i;
  end

`ifdef SIM_KNOB_DBG
  logic r_dbg_err_d;
  always @(posedge clk) begin
    r_dbg_err_d <= err_o;
    if (rstn && (SIZE < 1)) begin
      $error("buffer_credit_reg_based: SIZE must be >= 1");
      $finish;
    end
    if (err_o && !r_dbg_err_d) $error("buffer_credit_reg_based: overflow, write dropped");
  end
`endif

endmodule

// File: tb/tb_buffer_credit_reg_based.sv
// Bench for buffer_credit_reg_based: three instances (SIZE 4, 3, 2) checked every cycle
// against a queue-based model with a 2-register loop-back path from launch to return.
module tb_buffer_credit_reg_based;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [2:0]      req_val, rdy, vin;
  logic [2:0][7:0] din;
  logic [2:0]      req_rdy, vout, err;
  logic [2:0][7:0] dout;
  logic [2:0]      crd0;
  logic [1:0]      crd1, crd2;

  buffer_credit_reg_based #(.SIZE(4), .DATA_WD(8)) u0 (
    .clk(clk), .rstn(rstn), .req_val_i(req_val[0]), .req_rdy_o(req_rdy[0]),
    .val_i(vin[0]), .dat_i(din[0]), .val_o(vout[0]), .dat_o(dout[0]),
    .rdy_i(rdy[0]), .cnt_crd_o(crd0), .err_o(err[0]));

  buffer_credit_reg_based #(.SIZE(3), .DATA_WD(8)) u1 (
    .clk(clk), .rstn(rstn), .req_val_i(req_val[1]), .req_rdy_o(req_rdy[1]),
    .val_i(vin[1]), .dat_i(din[1]), .val_o(vout[1]), .dat_o(dout[1]),
    .rdy_i(rdy[1]), .cnt_crd_o(crd1), .err_o(err[1]));

  buffer_credit_reg_based #(.SIZE(2), .DATA_WD(8)) u2 (
    .clk(clk), .rstn(rstn), .req_val_i(req_val[2]), .req_rdy_o(req_rdy[2]),
    .val_i(vin[2]), .dat_i(din[2]), .val_o(vout[2]), .dat_o(dout[2]),
    .rdy_i(rdy[2]), .cnt_crd_o(crd2), .err_o(err[2]));

  int n_tests = 0;
  int n_fail  = 0;

  int         SZ [3] = '{4, 3, 2};
  int         m_crd [3];
  logic [7:0] m_q [3][$];
  logic       m_err [3];
  int         m_popcnt [3];

  bit         lb_en [3];
  bit [1:0]   lb_v [3];
  logic [7:0] lb_d [3][2];
  logic [7:0] lb_dat [3];
  int         lb_cnt [3];

  function automatic logic [31:0] get_crd(int i);
    case (i)
      0:       return 32'(crd0);
      1:       return 32'(crd1);
      default: return 32'(crd2);
    endcase
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      m_crd[i] = SZ[i];
      m_q[i].delete();
      m_err[i] = 1'b0;
      m_popcnt[i] = 0;
      lb_en[i] = 1'b0;
      lb_v[i] = '0;
      lb_cnt[i] = 0;
      lb_dat[i] = 8'h00;
      req_val[i] = 1'b0;
      rdy[i] = 1'b0;
      vin[i] = 1'b0;
      din[i] = 8'h00;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("req_rdy", i, 32'(req_rdy[i]), 32'(m_crd[i] != 0));
      chk("cnt_crd", i, get_crd(i), 32'(m_crd[i]));
      chk("val_o", i, 32'(vout[i]), 32'(m_q[i].size() != 0));
      if (m_q[i].size() != 0) chk("dat_o", i, 32'(dout[i]), 32'(m_q[i][0]));
      chk("err_o", i, 32'(err[i]), 32'(m_err[i]));
    end
  endtask

  // One clock: apply loop-back returns, advance the model, then check after the edge.
  task automatic step();
    bit launch, pop, full;
    for (int i = 0; i < 3; i++) begin
      if (lb_en[i]) begin
        vin[i] = lb_v[i][1];
        din[i] = lb_d[i][1];
      end
      launch = req_val[i] && (m_crd[i] != 0);
      pop    = rdy[i] && (m_q[i].size() != 0);
      full   = (m_q[i].size() == SZ[i]);
      m_crd[i] = m_crd[i] + int'(pop) - int'(launch);
      if (pop) begin
        void'(m_q[i].pop_front());
        m_popcnt[i]++;
      end
      if (vin[i]) begin
        if (full && !pop) m_err[i] = 1'b1;
        else m_q[i].push_back(din[i]);
      end
      lb_v[i][1] = lb_v[i][0];
      lb_d[i][1] = lb_d[i][0];
      lb_v[i][0] = launch;
      lb_d[i][0] = lb_dat[i];
      if (launch) begin
        lb_dat[i] = lb_dat[i] + 8'h01;
        lb_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rstn = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_all();

    // Credit drain: SIZE=4, consumer stalled, returns 0x10..0x13.
    lb_en[0] = 1'b1;
    lb_dat[0] = 8'h10;
    req_val[0] = 1'b1;
    rdy[0] = 1'b0;
    repeat (8) step();
    chk("drain_rdy", 0, 32'(req_rdy[0]), 32'd0);
    chk("drain_val", 0, 32'(vout[0]), 32'd1);
    chk("drain_dat", 0, 32'(dout[0]), 32'h10);
    chk("drain_err", 0, 32'(err[0]), 32'd0);

    // Two pops bring credits to 2, then launch and pop together.
    req_val[0] = 1'b0;
    rdy[0] = 1'b1;
    repeat (2) step();
    chk("crd_two", 0, get_crd(0), 32'd2);
    req_val[0] = 1'b1;
    step();
    chk("launch_pop_crd", 0, get_crd(0), 32'd2);
    req_val[0] = 1'b0;
    repeat (8) step();

    // Streaming 20 values with the consumer always ready.
    lb_cnt[0] = 0;
    lb_dat[0] = 8'h40;
    m_popcnt[0] = 0;
    rdy[0] = 1'b1;
    for (int c = 0; c < 60 && m_popcnt[0] < 20; c++) begin
      req_val[0] = (lb_cnt[0] < 20);
      step();
      chk("stream_crd_nz", 0, 32'(get_crd(0) != 0), 32'd1);
      if (m_popcnt[0] > 0 && m_popcnt[0] < 20) chk("stream_gap", 0, 32'(vout[0]), 32'd1);
    end
    chk("stream_done", 0, 32'(m_popcnt[0]), 32'd20);

    // Reset asserted mid-stream takes effect without a clock edge.
    req_val[0] = 1'b1;
    rdy[0] = 1'b0;
    repeat (3) step();
    rstn = 1'b0;
    #1;
    chk("rst_crd", 0, get_crd(0), 32'd4);
    chk("rst_rdy", 0, 32'(req_rdy[0]), 32'd1);
    chk("rst_val", 0, 32'(vout[0]), 32'd0);
    chk("rst_err", 0, 32'(err[0]), 32'd0);
    reset_model();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_all();

    // Wrap-around with SIZE=3 and a randomly stalling consumer.
    lb_en[1] = 1'b1;
    lb_dat[1] = 8'hA0;
    for (int c = 0; c < 200 && m_popcnt[1] < 7; c++) begin
      req_val[1] = (lb_cnt[1] < 7);
      rdy[1] = 1'($urandom_range(0, 1));
      step();
    end
    chk("wrap_done", 1, 32'(m_popcnt[1]), 32'd7);
    req_val[1] = 1'b0;
    rdy[1] = 1'b0;

    // Overflow with SIZE=2: fill, then force a write while full.
    req_val[2] = 1'b1;
    vin[2] = 1'b1;
    din[2] = 8'h01;
    step();
    din[2] = 8'h02;
    step();
    req_val[2] = 1'b0;
    din[2] = 8'hEE;
    step();
    chk("ovf_err", 2, 32'(err[2]), 32'd1);
    chk("ovf_dat", 2, 32'(dout[2]), 32'h01);
    vin[2] = 1'b0;
    repeat (3) step();
    rdy[2] = 1'b1;
    repeat (4) step();
    chk("ovf_err_sticky", 2, 32'(err[2]), 32'd1);
    chk("ovf_empty", 2, 32'(vout[2]), 32'd0);
    chk("ovf_pops", 2, 32'(m_popcnt[2]), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
